// File: rtl/uart_tx_fifo_param_if.sv
// Producer-side and line-side signals of the buffered UART transmitter.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_tx_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 16
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  ready;
  logic                  drop;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop2;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tx_out;
  logic                  busy;
  logic [CntW-1:0]       fifo_count;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    output stop2,
    output prescale,
    input  ready,
    input  drop,
    input  tx_out,
    input  busy,
    input  fifo_count
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    input  stop2,
    input  prescale,
    output ready,
    output drop,
    output tx_out,
    output busy,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO of words, LSB-first framing with optional parity,
// one or two stop bits and a programmable bit period of prescale+1 clocks.
module uart_tx_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  uart_tx_fifo_param_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Frame registers, captured on pop so mid-frame input changes are ignored
  state_e                state_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] tick_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  last_tick;
  logic                  frame_end;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO refuses writes even when a pop frees a slot on the same edge.
  assign push  = bus.data_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  assign last_tick = (tick_q == pre_q);
  assign frame_end = last_tick &&
                     (((state_q == StStop1) && !stop2_q) || (state_q == StStop2));
  // Popping at the end of the last stop bit chains frames with no idle gap.
  assign pop       = !empty && ((state_q == StIdle) || frame_end);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.p_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      state_q   <= StStart;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= head;
      pre_q     <= bus.prescale;
      par_en_q  <= bus.par_en;
      par_bit_q <= bus.par_typ ? ^head : ~^head;
      stop2_q   <= bus.stop2;
    end else if (state_q == StIdle) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (!last_tick) begin
      tick_q <= tick_q + PRESCALE_W'(1);
    end else begin
      tick_q <= '0;
      unique case (state_q)
        StStart: begin
          state_q <= StData;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          idx_q   <= '0;
        end
        StData: begin
          if (idx_q == LastIdx) begin
            if (par_en_q) begin
              state_q <= StParity;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= StStop1;
              tx_q    <= 1'b1;
            end
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= idx_q + IdxW'(1);
          end
        end
        StParity: begin
          state_q <= StStop1;
          tx_q    <= 1'b1;
        end
        StStop1: begin
          tx_q <= 1'b1;
          if (stop2_q) begin
            state_q <= StStop2;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.ready      = !full;
  assign bus.drop       = bus.data_valid && full;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: line waveforms are compared against
// frames built from the framing rules, FIFO occupancy against a queue model.
module tb_uart_tx_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 16;

  typedef bit bitq_t[$];

  logic clk;
  logic reset;
  int   total;
  int   passed;

  logic  txs[$];
  logic  bss[$];
  bit    exp_tx[$];
  bit    exp_busy[$];
  int    seg_lo[$];
  int    seg_hi[$];
  string seg_name[$];

  uart_tx_fifo_param_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) bus ();

  uart_tx_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Line image of one frame, one entry per clock.
  function automatic bitq_t frame_bits(logic [DW-1:0] w, bit pe, bit pt, bit s2, int pre);
    bitq_t q;
    bit    b[$];
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(w[i]);
    if (pe) b.push_back(pt ? ^w : ~^w);
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    foreach (b[i]) repeat (pre + 1) q.push_back(b[i]);
    return q;
  endfunction

  function automatic int frame_len(bit pe, bit s2, int pre);
    return (2 + DW + int'(pe) + int'(s2)) * (pre + 1);
  endfunction

  function automatic void add_frame(string nm, logic [DW-1:0] w, bit pe, bit pt, bit s2,
                                    int pre);
    bitq_t q;
    q = frame_bits(w, pe, pt, s2, pre);
    seg_lo.push_back(exp_tx.size());
    foreach (q[j]) begin
      exp_tx.push_back(q[j]);
      exp_busy.push_back(1'b1);
    end
    seg_hi.push_back(exp_tx.size());
    seg_name.push_back(nm);
  endfunction

  function automatic void add_idle(string nm, int n);
    seg_lo.push_back(exp_tx.size());
    for (int j = 0; j < n; j++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
    seg_hi.push_back(exp_tx.size());
    seg_name.push_back(nm);
  endfunction

  // Index of the first sample in [lo,hi) that differs from the expectation, else -1.
  function automatic int first_diff(int lo, int hi);
    if (txs.size() < hi) return lo;
    for (int i = lo; i < hi; i++) begin
      if (txs[i] !== logic'(exp_tx[i]) || bss[i] !== logic'(exp_busy[i])) return i;
    end
    return -1;
  endfunction

  task automatic clear_stream();
    txs.delete();
    bss.delete();
    exp_tx.delete();
    exp_busy.delete();
    seg_lo.delete();
    seg_hi.delete();
    seg_name.delete();
  endtask

  task automatic sample();
    @(negedge clk);
    txs.push_back(bus.tx_out);
    bss.push_back(bus.busy);
  endtask

  task automatic set_cfg(bit pe, bit pt, bit s2, int pre);
    bus.par_en   = pe;
    bus.par_typ  = pt;
    bus.stop2    = s2;
    bus.prescale = PW'(pre);
  endtask

  task automatic do_reset();
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.tx_out !== 1'b1) $display("FAIL reset_tx: got %b, required 1", bus.tx_out);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy);
    else passed++;
    total++;
    if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.ready);
    else passed++;
    total++;
    if (bus.drop !== 1'b0) $display("FAIL reset_drop: got %b, required 0", bus.drop);
    else passed++;
    total++;
    if (bus.fifo_count !== 3'd0) $display("FAIL reset_count: got %0d, required 0", bus.fifo_count);
    else passed++;
  endtask

  task automatic test_legacy_frame();
    logic [10:0] pat;
    int          nbusy;
    pat = 11'b01010010101;
    do_reset();
    clear_stream();
    set_cfg(1'b1, 1'b1, 1'b0, 0);
    bus.p_data     = 8'hA5;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sample();
      bus.data_valid = 1'b0;
    end
    add_idle("legacy_lead", 1);
    seg_lo.push_back(exp_tx.size());
    for (int j = 10; j >= 0; j--) begin
      exp_tx.push_back(pat[j]);
      exp_busy.push_back(1'b1);
    end
    seg_hi.push_back(exp_tx.size());
    seg_name.push_back("legacy_a5");
    add_idle("legacy_tail", 2);
    for (int f = 0; f < seg_lo.size(); f++) begin
      int d;
      d = first_diff(seg_lo[f], seg_hi[f]);
      total++;
      if (d !== -1)
        $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                 txs[d], bss[d], exp_tx[d], exp_busy[d]);
      else passed++;
    end
    nbusy = 0;
    foreach (bss[i]) if (bss[i] === 1'b1) nbusy++;
    total++;
    if (nbusy !== 11) $display("FAIL legacy_busy_len: got %0d cycles, required 11", nbusy);
    else passed++;
  endtask

  task automatic test_prescale_stop2();
    int nbusy;
    int len;
    do_reset();
    clear_stream();
    set_cfg(1'b0, 1'b0, 1'b1, 3);
    len = frame_len(1'b0, 1'b1, 3);
    bus.p_data     = 8'h0F;
    bus.data_valid = 1'b1;
    for (int i = 0; i < len + 3; i++) begin
      sample();
      bus.data_valid = 1'b0;
    end
    add_idle("pre3_lead", 1);
    add_frame("pre3_0f", 8'h0F, 1'b0, 1'b0, 1'b1, 3);
    add_idle("pre3_tail", 2);
    for (int f = 0; f < seg_lo.size(); f++) begin
      int d;
      d = first_diff(seg_lo[f], seg_hi[f]);
      total++;
      if (d !== -1)
        $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                 txs[d], bss[d], exp_tx[d], exp_busy[d]);
      else passed++;
    end
    nbusy = 0;
    foreach (bss[i]) if (bss[i] === 1'b1) nbusy++;
    total++;
    if (nbusy !== 44) $display("FAIL pre3_busy_len: got %0d cycles, required 44", nbusy);
    else passed++;
  endtask

  task automatic test_random_frames();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      logic [DW-1:0] w;
      bit            pe, pt, s2;
      int            pre;
      clear_stream();
      w   = DW'($urandom);
      pe  = bit'($urandom_range(0, 1));
      pt  = bit'($urandom_range(0, 1));
      s2  = bit'($urandom_range(0, 1));
      pre = int'($urandom_range(0, 3));
      set_cfg(pe, pt, s2, pre);
      bus.p_data     = w;
      bus.data_valid = 1'b1;
      for (int i = 0; i < frame_len(pe, s2, pre) + 3; i++) begin
        sample();
        bus.data_valid = 1'b0;
      end
      add_idle("rand_lead", 1);
      add_frame($sformatf("rand_frame%0d_%02h", r, w), w, pe, pt, s2, pre);
      add_idle("rand_tail", 2);
      for (int f = 0; f < seg_lo.size(); f++) begin
        int d;
        d = first_diff(seg_lo[f], seg_hi[f]);
        total++;
        if (d !== -1)
          $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                   txs[d], bss[d], exp_tx[d], exp_busy[d]);
        else passed++;
      end
    end
  endtask

  // Spec scenario 4: five writes while a frame is on the line.
  task automatic test_back_to_back();
    logic [DW-1:0] w[6];
    logic [DW-1:0] model_q[$];
    bit            pe, pt, s2;
    int            len;
    do_reset();
    clear_stream();
    foreach (w[k]) w[k] = DW'($urandom);
    pe  = bit'($urandom_range(0, 1));
    pt  = bit'($urandom_range(0, 1));
    s2  = bit'($urandom_range(0, 1));
    len = frame_len(pe, s2, 1);
    set_cfg(pe, pt, s2, 1);
    bus.p_data     = w[0];
    bus.data_valid = 1'b1;
    for (int i = 0; i < 1 + 5 * len + 2; i++) begin
      sample();
      bus.data_valid = 1'b0;
      if (i == 6) begin
        total++;
        if (bus.fifo_count !== 3'(model_q.size()))
          $display("FAIL b2b_count: got %0d, required %0d", bus.fifo_count, model_q.size());
        else passed++;
      end
      if (i >= 1 && i <= 5) begin
        bit exp_ready;
        exp_ready      = (model_q.size() < DEPTH);
        bus.p_data     = w[i];
        bus.data_valid = 1'b1;
        #1;
        total++;
        if (bus.ready !== exp_ready)
          $display("FAIL b2b_ready_w%0d: got %b, required %b", i, bus.ready, exp_ready);
        else passed++;
        total++;
        if (bus.drop !== !exp_ready)
          $display("FAIL b2b_drop_w%0d: got %b, required %b", i, bus.drop, !exp_ready);
        else passed++;
        if (exp_ready) model_q.push_back(w[i]);
      end
    end
    add_idle("b2b_lead", 1);
    add_frame("b2b_frame0", w[0], pe, pt, s2, 1);
    foreach (model_q[k]) add_frame($sformatf("b2b_queued%0d", k), model_q[k], pe, pt, s2, 1);
    add_idle("b2b_tail", 2);
    for (int f = 0; f < seg_lo.size(); f++) begin
      int d;
      d = first_diff(seg_lo[f], seg_hi[f]);
      total++;
      if (d !== -1)
        $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                 txs[d], bss[d], exp_tx[d], exp_busy[d]);
      else passed++;
    end
  endtask

  // Settings change during the first frame's data bits apply only to the next frame.
  task automatic test_cfg_change();
    logic [DW-1:0] w0, w1;
    bit            pt_b;
    int            n;
    do_reset();
    clear_stream();
    w0   = DW'($urandom);
    w1   = DW'($urandom);
    pt_b = bit'($urandom_range(0, 1));
    n    = 1 + frame_len(1'b0, 1'b0, 1) + frame_len(1'b1, 1'b1, 2) + 2;
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    bus.p_data     = w0;
    bus.data_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      sample();
      bus.data_valid = 1'b0;
      if (i == 0) begin
        bus.p_data     = w1;
        bus.data_valid = 1'b1;
      end
      if (i == 6) set_cfg(1'b1, pt_b, 1'b1, 2);
    end
    add_idle("cfg_lead", 1);
    add_frame("cfg_frame_old", w0, 1'b0, 1'b0, 1'b0, 1);
    add_frame("cfg_frame_new", w1, 1'b1, pt_b, 1'b1, 2);
    add_idle("cfg_tail", 2);
    for (int f = 0; f < seg_lo.size(); f++) begin
      int d;
      d = first_diff(seg_lo[f], seg_hi[f]);
      total++;
      if (d !== -1)
        $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                 txs[d], bss[d], exp_tx[d], exp_busy[d]);
      else passed++;
    end
  endtask

  // Frame 0 ends on the edge after sample 10; a write lands on that same edge.
  task automatic test_push_pop();
    logic [DW-1:0] w[4];
    do_reset();
    clear_stream();
    foreach (w[k]) w[k] = DW'($urandom);
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    bus.p_data     = w[0];
    bus.data_valid = 1'b1;
    for (int i = 0; i < 1 + 4 * frame_len(1'b0, 1'b0, 0) + 2; i++) begin
      sample();
      bus.data_valid = 1'b0;
      if (i == 10 || i == 11) begin
        total++;
        if (bus.fifo_count !== 3'd2)
          $display("FAIL pushpop_count_s%0d: got %0d, required 2", i, bus.fifo_count);
        else passed++;
      end
      if (i == 0 || i == 1 || i == 10) begin
        bus.p_data     = (i == 10) ? w[3] : w[i + 1];
        bus.data_valid = 1'b1;
      end
    end
    add_idle("pushpop_lead", 1);
    foreach (w[k]) add_frame($sformatf("pushpop_frame%0d", k), w[k], 1'b0, 1'b0, 1'b0, 0);
    add_idle("pushpop_tail", 2);
    for (int f = 0; f < seg_lo.size(); f++) begin
      int d;
      d = first_diff(seg_lo[f], seg_hi[f]);
      total++;
      if (d !== -1)
        $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=%b", seg_name[f], d,
                 txs[d], bss[d], exp_tx[d], exp_busy[d]);
      else passed++;
    end
  endtask

  // Reset asserted between clock edges while a frame is in its data bits.
  task automatic test_reset_midframe();
    int bad;
    do_reset();
    clear_stream();
    set_cfg(1'b0, 1'b0, 1'b0, 2);
    bus.p_data     = DW'($urandom);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sample();
      bus.data_valid = 1'b0;
      if (i == 0 || i == 1) begin
        bus.p_data     = DW'($urandom);
        bus.data_valid = 1'b1;
      end
    end
    total++;
    if (bus.busy !== 1'b1) $display("FAIL midreset_precond_busy: got %b, required 1", bus.busy);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus.tx_out !== 1'b1) $display("FAIL midreset_tx: got %b, required 1", bus.tx_out);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b, required 0", bus.busy);
    else passed++;
    total++;
    if (bus.fifo_count !== 3'd0)
      $display("FAIL midreset_count: got %0d, required 0", bus.fifo_count);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL midreset_no_frame: got %0d active cycles, required 0", bad);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_legacy_frame();
    test_prescale_stop2();
    test_random_frames();
    test_back_to_back();
    test_cfg_change();
    test_push_pop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
